// File: rtl/catzip_pkg.sv
// Shared ASCII constants and dumper state encoding for the ROM hex dumper.
// The PREFIX state only exists when CATZIP_DUMP_ADDR_PREFIX_EN is defined.
package catzip_pkg;

  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_COLON = 8'h3A;
  localparam logic [7:0] CHR_ZERO  = 8'h30;
  localparam logic [7:0] CHR_A     = 8'h41;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_ACK1,
    ST_ACK,
    ST_SEP,
    ST_LF,
    ST_DONE
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
    , ST_PREFIX
`endif
  } dump_state_e;

endpackage

// File: rtl/rom_hex_dumper_if.sv
// ROM-side and UART-side signals of the hex dumper, bundled for the top-level port.
interface rom_hex_dumper_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [7:0]            tx_data;
  logic                  tx_send;
  logic                  tx_busy;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, first_addr, last_addr, rom_data, tx_busy,
    output rom_addr, tx_data, tx_send, busy, done
  );

  modport master (
    output start, first_addr, last_addr, rom_data, tx_busy,
    input  rom_addr, tx_data, tx_send, busy, done
  );
endinterface

// File: rtl/hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
module hex_ascii
  import catzip_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] chr_o
);
  always_comb begin
    if (nib_i < 4'd10) chr_o = CHR_ZERO + {4'd0, nib_i};
    else               chr_o = CHR_A + {4'd0, nib_i} - 8'd10;
  end
endmodule

// File: rtl/rom_hex_dumper.sv
// Dumps a ROM address range as uppercase ASCII hex words over a UART byte interface.
// Optional per-line address prefix ("AAA: ") enabled by CATZIP_DUMP_ADDR_PREFIX_EN.
module rom_hex_dumper
  import catzip_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 8
) (
  input logic           clk,
  input logic           rst_n,
  rom_hex_dumper_if.slave bus
);
  localparam int DIGITS = DATA_WIDTH / 4;
  localparam int NIB_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [NIB_W-1:0] NIB_TOP   = NIB_W'(DIGITS - 1);
  localparam logic [7:0]       LINE_LAST = 8'(WORDS_PER_LINE - 1);

  dump_state_e           state_q, state_d, ret_q, ret_d;
  logic [ADDR_WIDTH-1:0] addr_q, last_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [NIB_W-1:0]      nib_q;
  logic [7:0]            line_q, tx_data_q, send_byte, word_chr;
  logic                  tx_send_q, send_fire, at_last, line_full;

  assign at_last      = (addr_q == last_q);
  assign line_full    = (line_q == LINE_LAST);
  assign bus.rom_addr = addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_send  = tx_send_q;

  hex_ascii u_word_chr (.nib_i(word_q[DATA_WIDTH-1 -: 4]), .chr_o(word_chr));

`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
  localparam int PFX_DIGITS = (ADDR_WIDTH + 3) / 4;
  localparam int PFX_BITS   = 4 * PFX_DIGITS;
  localparam int PFX_W      = $clog2(PFX_DIGITS + 2);
  localparam logic [PFX_W-1:0] PFX_COLON = PFX_W'(PFX_DIGITS);
  localparam logic [PFX_W-1:0] PFX_LAST  = PFX_W'(PFX_DIGITS + 1);

  logic [PFX_W-1:0]    pfx_q;
  logic [PFX_BITS-1:0] addr_pad, addr_shift;
  logic [7:0]          addr_chr;

  // Digit index walks most-significant first; colon and space follow the digits.
  assign addr_pad   = PFX_BITS'(addr_q);
  assign addr_shift = addr_pad >> (4 * (PFX_DIGITS - 1 - int'(pfx_q)));

  hex_ascii u_addr_chr (.nib_i(addr_shift[3:0]), .chr_o(addr_chr));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Every byte goes out through ACK1 (UART busy not yet visible) then ACK.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        state_d = ST_EMIT;
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
        if (line_q == 8'd0) state_d = ST_PREFIX;
`endif
      end
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
      ST_PREFIX: if (!bus.tx_busy) begin
        state_d = ST_ACK1;
        ret_d   = (pfx_q == PFX_LAST) ? ST_EMIT : ST_PREFIX;
      end
`endif
      ST_EMIT: if (!bus.tx_busy) begin
        state_d = ST_ACK1;
        ret_d   = (nib_q == '0) ? ST_SEP : ST_EMIT;
      end
      ST_ACK1:  state_d = ST_ACK;
      ST_ACK:   if (!bus.tx_busy) state_d = ret_q;
      ST_SEP: if (!bus.tx_busy) begin
        state_d = ST_ACK1;
        ret_d   = (at_last || line_full) ? ST_LF : ST_FETCH;
      end
      ST_LF: if (!bus.tx_busy) begin
        state_d = ST_ACK1;
        ret_d   = at_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q != ST_IDLE);
    bus.done  = (state_q == ST_DONE);
    send_fire = 1'b0;
    send_byte = 8'h00;
    case (state_q)
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
      ST_PREFIX: begin
        send_fire = !bus.tx_busy;
        if (pfx_q == PFX_LAST)       send_byte = CHR_SPACE;
        else if (pfx_q == PFX_COLON) send_byte = CHR_COLON;
        else                         send_byte = addr_chr;
      end
`endif
      ST_EMIT: begin
        send_fire = !bus.tx_busy;
        send_byte = word_chr;
      end
      ST_SEP: begin
        send_fire = !bus.tx_busy;
        send_byte = (at_last || line_full) ? CHR_CR : CHR_SPACE;
      end
      ST_LF: begin
        send_fire = !bus.tx_busy;
        send_byte = CHR_LF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      last_q    <= '0;
      line_q    <= 8'd0;
      nib_q     <= '0;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
      pfx_q     <= '0;
`endif
    end else begin
      tx_send_q <= send_fire;
      if (send_fire) tx_data_q <= send_byte;
      case (state_q)
        ST_IDLE: if (bus.start) begin
          addr_q <= bus.first_addr;
          last_q <= bus.last_addr;
          line_q <= 8'd0;
        end
        ST_FETCH: begin
          nib_q <= NIB_TOP;
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
          pfx_q <= '0;
`endif
        end
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
        ST_PREFIX: if (send_fire) pfx_q <= pfx_q + 1'b1;
`endif
        ST_EMIT: if (send_fire) nib_q <= nib_q - 1'b1;
        // The address advances with the last separator byte of a word.
        ST_SEP: if (send_fire && !at_last) begin
          if (line_full) begin
            line_q <= 8'd0;
          end else begin
            line_q <= line_q + 8'd1;
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_LF: if (send_fire && !at_last) addr_q <= addr_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_FETCH)                  word_q <= bus.rom_data;
    else if (state_q == ST_EMIT && send_fire) word_q <= word_q << 4;
  end
endmodule

// File: tb/tb_rom_hex_dumper.sv
// Directed bench for rom_hex_dumper: two instances (8 and 2 words per line) with UART and ROM models.
module tb_rom_hex_dumper;
`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
  localparam bit PFX_EN = 1'b1;
`else
  localparam bit PFX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  rom_hex_dumper_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) if8 ();
  rom_hex_dumper_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) if2 ();

  rom_hex_dumper #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .WORDS_PER_LINE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave));
  rom_hex_dumper #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .WORDS_PER_LINE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  function automatic logic [15:0] rom_fn(input logic [11:0] a);
    case (a)
      12'h000: return 16'h1234;
      12'h001: return 16'hABCD;
      12'h002: return 16'h00F0;
      12'h010: return 16'h5A5A;
      12'h011: return 16'h0001;
      12'h012: return 16'hFFFF;
      12'h013: return 16'h9E37;
      12'h020: return 16'hBEEF;
      12'hFFF: return 16'hC0DE;
      default: return 16'h0000;
    endcase
  endfunction

  assign if8.rom_data = rom_fn(if8.rom_addr);
  assign if2.rom_data = rom_fn(if2.rom_addr);

  // UART models: busy for busy_len cycles starting the cycle after a send.
  byte cap8[$];
  byte cap2[$];
  int  busy_len8 = 10;
  int  cnt8 = 0, cnt2 = 0;
  int  done8 = 0, done2 = 0;
  int  b2b8 = 0, b2b2 = 0;
  logic prev8 = 1'b0, prev2 = 1'b0;

  assign if8.tx_busy = (cnt8 != 0);
  assign if2.tx_busy = (cnt2 != 0);

  always @(posedge clk) begin
    if (if8.tx_send) begin
      cap8.push_back(if8.tx_data);
      cnt8 <= busy_len8;
    end else if (cnt8 != 0) begin
      cnt8 <= cnt8 - 1;
    end
    if (if8.tx_send && prev8) b2b8 <= b2b8 + 1;
    prev8 <= if8.tx_send;
    if (if8.done) done8 <= done8 + 1;

    if (if2.tx_send) begin
      cap2.push_back(if2.tx_data);
      cnt2 <= 10;
    end else if (cnt2 != 0) begin
      cnt2 <= cnt2 - 1;
    end
    if (if2.tx_send && prev2) b2b2 <= b2b2 + 1;
    prev2 <= if2.tx_send;
    if (if2.done) done2 <= done2 + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string hx3(input logic [11:0] v);
    string s;
    byte   c;
    s = "";
    for (int i = 2; i >= 0; i--) begin
      c = (v[4*i +: 4] < 4'd10) ? 8'h30 + 8'(v[4*i +: 4]) : 8'h37 + 8'(v[4*i +: 4]);
      s = {s, $sformatf("%c", c)};
    end
    return s;
  endfunction

  function automatic string pfx(input logic [11:0] a);
    return PFX_EN ? {hx3(a), ": "} : "";
  endfunction

  function automatic int cap_size(input int d);
    return (d == 0) ? cap8.size() : cap2.size();
  endfunction

  function automatic byte cap_at(input int d, input int i);
    if (i >= cap_size(d)) return 8'h00;
    return (d == 0) ? cap8[i] : cap2[i];
  endfunction

  function automatic int done_of(input int d);
    return (d == 0) ? done8 : done2;
  endfunction

  task automatic start_dump(input int d, input logic [11:0] first, input logic [11:0] last);
    @(negedge clk);
    if (d == 0) begin
      if8.first_addr = first; if8.last_addr = last; if8.start = 1'b1;
    end else begin
      if2.first_addr = first; if2.last_addr = last; if2.start = 1'b1;
    end
    @(negedge clk);
    if8.start = 1'b0;
    if2.start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int dbase, input int budget);
    int n;
    n = 0;
    while (done_of(d) == dbase && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_dump(input int d, input int base, input string tag, input string exp);
    check({tag, "_len"}, cap_size(d) - base, exp.len());
    for (int i = 0; i < exp.len(); i++)
      check($sformatf("%s_b%0d", tag, i), cap_at(d, base + i), exp[i]);
  endtask

  string crlf;
  int    base, dbase, bb, n;

  initial begin
    crlf = "\015\012";
    if8.start = 1'b0; if8.first_addr = '0; if8.last_addr = '0;
    if2.start = 1'b0; if2.first_addr = '0; if2.last_addr = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rom_addr", if8.rom_addr, 0);
    check("rst_tx_data", if8.tx_data, 0);
    check("rst_tx_send", if8.tx_send, 0);
    check("rst_busy", if8.busy, 0);
    check("rst_done", if8.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic three-word dump
    base = cap8.size(); dbase = done8; bb = b2b8;
    start_dump(0, 12'h000, 12'h002);
    check("t1_busy_run", if8.busy, 1);
    wait_done(0, dbase, 3000);
    check_dump(0, base, "t1", {pfx(12'h000), "1234 ABCD 00F0", crlf});
    check("t1_done_cnt", done8 - dbase, 1);
    check("t1_busy_end", if8.busy, 0);
    check("t1_b2b", b2b8 - bb, 0);

    // Two words per line, four words
    base = cap2.size(); dbase = done2; bb = b2b2;
    start_dump(1, 12'h010, 12'h013);
    wait_done(1, dbase, 4000);
    check_dump(1, base, "t2", {pfx(12'h010), "5A5A 0001", crlf, pfx(12'h012), "FFFF 9E37", crlf});
    check("t2_done_cnt", done2 - dbase, 1);
    check("t2_b2b", b2b2 - bb, 0);

    // Address wrap-around
    base = cap8.size(); dbase = done8;
    start_dump(0, 12'hFFF, 12'h001);
    wait_done(0, dbase, 3000);
    check_dump(0, base, "t3", {pfx(12'hFFF), "C0DE 1234 ABCD", crlf});
    check("t3_done_cnt", done8 - dbase, 1);

    // Long UART busy on first byte, plus an ignored start while busy
    base = cap8.size(); dbase = done8; bb = b2b8;
    busy_len8 = 50;
    start_dump(0, 12'h000, 12'h002);
    n = 0;
    while (cap8.size() == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    busy_len8 = 10;
    repeat (20) @(negedge clk);
    start_dump(0, 12'h010, 12'h013);
    repeat (18) @(negedge clk);
    check("t4_hold_one_byte", cap8.size() - base, 1);
    check("t4_busy_mid", if8.busy, 1);
    wait_done(0, dbase, 3000);
    check_dump(0, base, "t4", {pfx(12'h000), "1234 ABCD 00F0", crlf});
    check("t4_done_cnt", done8 - dbase, 1);
    check("t4_b2b", b2b8 - bb, 0);

    // Reset mid-dump after the third byte, then a fresh dump
    base = cap8.size();
    start_dump(0, 12'h000, 12'h002);
    n = 0;
    while (cap8.size() < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_tx_send", if8.tx_send, 0);
    check("t5_busy", if8.busy, 0);
    check("t5_rom_addr", if8.rom_addr, 0);
    repeat (30) @(negedge clk);
    check("t5_no_flush", cap8.size() - base, 3);
    base = cap8.size(); dbase = done8;
    start_dump(0, 12'h000, 12'h002);
    wait_done(0, dbase, 3000);
    check_dump(0, base, "t5", {pfx(12'h000), "1234 ABCD 00F0", crlf});
    check("t5_done_cnt", done8 - dbase, 1);

`ifdef CATZIP_DUMP_ADDR_PREFIX_EN
    // Single word with address prefix
    base = cap8.size(); dbase = done8;
    start_dump(0, 12'h020, 12'h020);
    wait_done(0, dbase, 3000);
    check_dump(0, base, "t6", {"020: BEEF", crlf});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_hex_dumper.md
Name: rom_hex_dumper

Overview:
- Transmit-side companion to the UART command/ROM path: on a start pulse, reads a range of words from the combinational ROM (16-bit data, 12-bit address).
- Streams each word out as uppercase ASCII hex over one UART byte-send interface.
- Sits between the `rom` instance and a `uart` instance's `send`/`tx_data` inputs, replacing the echo path for that UART when selected.

Parameters:
- ADDR_WIDTH, 12, ROM address width.
- DATA_WIDTH, 16, ROM word width; must be a multiple of 4. Digits per word = DATA_WIDTH/4.
- WORDS_PER_LINE, 8, words per output line before CR LF; range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begin dump (ignored while busy=1)
- first_addr  in  ADDR_WIDTH  first ROM address, sampled on accepted start
- last_addr  in  ADDR_WIDTH  last ROM address (inclusive), sampled on accepted start
- rom_addr  out  ADDR_WIDTH  address to ROM
- rom_data  in  DATA_WIDTH  ROM data, combinational from rom_addr
- tx_data  out  8  byte to UART
- tx_send  out  1  one-cycle send strobe to UART
- tx_busy  in  1  UART transmitter busy
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after final byte accepted

Behaviour:
- Reset values (rst_n=0 at clk edge): state IDLE, rom_addr=0, tx_data=0, tx_send=0, busy=0, done=0, word/line counters 0.
- IDLE: on start=1, latch first/last into internal registers, rom_addr<=first_addr, busy<=1, go FETCH.
- FETCH (1 cycle): register rom_data into word shift register; nibble counter <= DATA_WIDTH/4-1; go EMIT.
- EMIT: when tx_busy=0, drive tx_data=ASCII of top nibble ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), pulse tx_send, shift word left 4; go ACK.
- ACK: ignore tx_busy for exactly 1 cycle (UART raises busy the cycle after send), then wait until tx_busy=0. Return to the next emit state: EMIT again until all digits are sent, then SEP.
- SEP:
  - If rom_addr==last_addr: send CR (0x0D), then LF (0x0A), then DONE.
  - Else if line word count == WORDS_PER_LINE-1: send CR, then LF, then clear the count.
  - Else: send space (0x20) and increment the count.
  - Then rom_addr <= rom_addr+1 (mod 2^ADDR_WIDTH) and go FETCH.
- DONE: done=1 for 1 cycle, busy<=0, go IDLE.
- Every byte uses the same EMIT/ACK handshake. tx_send is never high on two consecutive cycles. tx_data is held stable from the send cycle until the next send.
- Wrap-around: if last_addr < first_addr, addresses wrap through 2^ADDR_WIDTH-1 to 0 and stop at last_addr. first==last dumps exactly one word.
- start while busy=1: ignored; no restart.
- start and reset in the same cycle: reset wins.
- Reset mid-dump: immediate return to IDLE. tx_send=0 in the next cycle. No CR LF is flushed.
- Byte count per dump (no prefix) = N*(DATA_WIDTH/4+1) + ceil(N/WORDS_PER_LINE) for N words.

Optional Feature:
- Macro CATZIP_DUMP_ADDR_PREFIX_EN.
- When defined: each line starts with the current rom_addr as ceil(ADDR_WIDTH/4) uppercase hex digits, then ':' (0x3A) and a space, before the first word of the line. Adds a PREFIX state entered from FETCH when the line word count is 0.
- When undefined: no prefix, and no PREFIX state is synthesized.

Decomposition:
- Shared package catzip_pkg holds:
  - ASCII constants: CHR_SPACE, CHR_CR, CHR_LF, CHR_COLON, CHR_ZERO, CHR_A.
  - The dumper state enumeration localparams.
- One sub-module, hex_ascii: combinational 4-bit nibble to 8-bit uppercase ASCII. Reused for the optional address prefix.

Test Plan:
- first=0x000, last=0x002, ROM[0..2]=0x1234,0xABCD,0x00F0, UART model busy 10 cycles per byte → bytes "1234 ABCD 00F0\r\n" (16 bytes), one done pulse, busy low afterwards.
- WORDS_PER_LINE=2, first=0x010, last=0x013 → "wwww wwww\r\nwwww wwww\r\n" with the correct ROM values; exactly 22 tx_send pulses.
- Wrap: first=0xFFF, last=0x001 → words from addresses 0xFFF,0x000,0x001 in that order; done after 16 bytes.
- tx_busy held high 50 cycles after the first send → no second tx_send until busy falls. Start pulsed during the dump → output unchanged.
- Reset (rst_n=0 for 1 cycle) after the 3rd byte → tx_send=0, busy=0 next cycle. A new start then produces a complete, correct dump.
- With CATZIP_DUMP_ADDR_PREFIX_EN, first=0x020, last=0x020, ROM=0xBEEF → "020: BEEF\r\n".
